// File: rtl/responder_array_if.sv
// Host-side bundle for the quiz responder: round control, player buttons,
// judge pulses and every status output of responder_array.
interface responder_array_if #(
  parameter int N_PLAYERS = 4,
  parameter int SCORE_W   = 4
);
  localparam int ID_W = (N_PLAYERS <= 2) ? 1 : $clog2(N_PLAYERS);

  // Host to responder
  logic                         Start;
  logic [N_PLAYERS-1:0]         Key_In;
  logic                         Judge_Ok;
  logic                         Judge_Fail;

  // Responder to host
  logic                         Winner_Valid;
  logic [ID_W-1:0]              Winner_Id;
  logic [N_PLAYERS-1:0]         LED_Out;
  logic [N_PLAYERS-1:0]         Foul;
  logic [3:0]                   TimerH;
  logic [3:0]                   TimerL;
  logic                         Time_Over;
  logic                         Buzzer_Req;
  logic [N_PLAYERS*SCORE_W-1:0] Score_Out;
  logic [2:0]                   State_Out;

  // Host / quiz-master side
  modport master (
    output Start, Key_In, Judge_Ok, Judge_Fail,
    input  Winner_Valid, Winner_Id, LED_Out, Foul, TimerH, TimerL,
           Time_Over, Buzzer_Req, Score_Out, State_Out
  );

  // Responder side
  modport slave (
    input  Start, Key_In, Judge_Ok, Judge_Fail,
    output Winner_Valid, Winner_Id, LED_Out, Foul, TimerH, TimerL,
           Time_Over, Buzzer_Req, Score_Out, State_Out
  );
endinterface

// File: rtl/responder_array.sv
// Quiz-show responder: first eligible button wins, false starts are flagged,
// the winner gets a BCD countdown to answer and the host judges the answer.
// Per-player scores saturate and persist across rounds until reset.
module responder_array #(
  parameter int N_PLAYERS  = 4,
  parameter int ANSWER_SEC = 30,
  parameter int TICK_CYC   = 50000000,
  parameter int SCORE_W    = 4
) (
  input logic             CLK,
  input logic             Rst,
  responder_array_if.slave bus
);

  localparam int ID_W  = (N_PLAYERS <= 2) ? 1 : $clog2(N_PLAYERS);
  localparam int PRE_W = $clog2(TICK_CYC);

  localparam logic [3:0]       ANS_H    = 4'(ANSWER_SEC / 10);
  localparam logic [3:0]       ANS_L    = 4'(ANSWER_SEC % 10);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    ANSWER  = 3'd2,
    TIMEOUT = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t               state;
  logic [N_PLAYERS-1:0] foul;
  logic                 winner_valid;
  logic [ID_W-1:0]      winner_id;
  logic [N_PLAYERS-1:0] led;
  logic                 buzzer;
  logic                 time_over;
  logic [3:0]           timer_h;
  logic [3:0]           timer_l;
  logic [PRE_W-1:0]     prescaler;
  logic [SCORE_W-1:0]   score [N_PLAYERS];

  logic [N_PLAYERS-1:0]         eligible;
  logic [N_PLAYERS-1:0]         win_onehot;
  logic [ID_W-1:0]              win_id;
  logic                         tick;
  logic                         final_tick;
  logic [N_PLAYERS*SCORE_W-1:0] score_flat;

  // Arbitration and tick decode: lowest-index eligible player wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    win_id     = '0;
    eligible   = bus.Key_In & ~foul;
    win_onehot = eligible & (~eligible + N_PLAYERS'(1));
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
    tick       = (prescaler == PRE_LAST);
    final_tick = tick && (timer_h == 4'd0) && (timer_l == 4'd1);
  end

  // Flatten the score array onto the output bus, player i at [i*SCORE_W +: SCORE_W].
  always_comb begin
    score_flat = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      score_flat[i*SCORE_W +: SCORE_W] = score[i];
    end
  end

  // Round FSM with all status outputs, countdown timer and scores registered.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      state        <= IDLE;
      foul         <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      led          <= '0;
      buzzer       <= 1'b0;
      time_over    <= 1'b0;
      timer_h      <= ANS_H;
      timer_l      <= ANS_L;
      prescaler    <= '0;
      // NOTE: the score array is real state that must read zero after reset,
      // so it is cleared element by element rather than left as plain storage.
      for (int i = 0; i < N_PLAYERS; i++) score[i] <= '0;
    end else begin
      buzzer <= 1'b0;
      if ((state != IDLE) && !bus.Start) begin
        // Dropping Start aborts any round; entry to IDLE clears the round outputs.
        state        <= IDLE;
        foul         <= '0;
        winner_valid <= 1'b0;
        winner_id    <= '0;
        led          <= '0;
        time_over    <= 1'b0;
        timer_h      <= ANS_H;
        timer_l      <= ANS_L;
        prescaler    <= '0;
      end else begin
        case (state)
          IDLE: begin
            // Any press before the round opens is a false start.
            foul <= foul | bus.Key_In;
            if (bus.Start) state <= ARMED;
          end

          ARMED: begin
            if (|eligible) begin
              winner_valid <= 1'b1;
              winner_id    <= win_id;
              led          <= win_onehot;
              buzzer       <= 1'b1;
              timer_h      <= ANS_H;
              timer_l      <= ANS_L;
              prescaler    <= '0;
              state        <= ANSWER;
            end
          end

          ANSWER: begin
            // A judge decision overrides the timer, even on the final tick.
            if (bus.Judge_Ok) begin
              if (score[winner_id] != SCORE_MAX) begin
                score[winner_id] <= score[winner_id] + SCORE_W'(1);
              end
              state <= DONE;
            end else if (bus.Judge_Fail) begin
              state <= DONE;
            end else if (tick) begin
              prescaler <= '0;
              if (final_tick) begin
                timer_h   <= 4'd0;
                timer_l   <= 4'd0;
                time_over <= 1'b1;
                buzzer    <= 1'b1;
                state     <= TIMEOUT;
              end else if (timer_l == 4'd0) begin
                timer_l <= 4'd9;
                timer_h <= timer_h - 4'd1;
              end else begin
                timer_l <= timer_l - 4'd1;
              end
            end else begin
              prescaler <= prescaler + PRE_W'(1);
            end
          end

          TIMEOUT, DONE: begin
            // Hold timer and winner until the host drops Start.
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Winner_Valid = winner_valid;
  assign bus.Winner_Id    = winner_id;
  assign bus.LED_Out      = led;
  assign bus.Foul         = foul;
  assign bus.TimerH       = timer_h;
  assign bus.TimerL       = timer_l;
  assign bus.Time_Over    = time_over;
  assign bus.Buzzer_Req   = buzzer;
  assign bus.Score_Out    = score_flat;
  assign bus.State_Out    = state;

endmodule

// File: tb/tb_responder_array.sv
// Directed bench for responder_array with 4 players, 30 s window, 4-cycle tick.
module tb_responder_array;

  localparam int N_PLAYERS  = 4;
  localparam int ANSWER_SEC = 30;
  localparam int TICK_CYC   = 4;
  localparam int SCORE_W    = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  responder_array_if #(.N_PLAYERS(N_PLAYERS), .SCORE_W(SCORE_W)) bus ();

  responder_array #(
    .N_PLAYERS (N_PLAYERS),
    .ANSWER_SEC(ANSWER_SEC),
    .TICK_CYC  (TICK_CYC),
    .SCORE_W   (SCORE_W)
  ) dut (
    .CLK(clk),
    .Rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [3:0]  key;
    logic        ok;
    logic        fail;
    logic [2:0]  st;
    logic        valid;
    logic [1:0]  id;
    logic [3:0]  led;
    logic [3:0]  foul;
    logic        buzz;
    logic [15:0] score;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic start, input logic [3:0] key, input logic ok, input logic fail);
    bus.Start      = start;
    bus.Key_In     = key;
    bus.Judge_Ok   = ok;
    bus.Judge_Fail = fail;
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic vec_t mk(input logic start, input logic [3:0] key, input logic ok,
                              input logic fail, input logic [2:0] st, input logic valid,
                              input logic [1:0] id, input logic [3:0] led, input logic [3:0] foul,
                              input logic buzz, input logic [15:0] score);
    vec_t v;
    v.start = start; v.key = key; v.ok = ok; v.fail = fail;
    v.st = st; v.valid = valid; v.id = id; v.led = led; v.foul = foul;
    v.buzz = buzz; v.score = score;
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, ".state"},     32'(bus.State_Out),    32'd0);
    check({tag, ".valid"},     32'(bus.Winner_Valid), 32'd0);
    check({tag, ".id"},        32'(bus.Winner_Id),    32'd0);
    check({tag, ".led"},       32'(bus.LED_Out),      32'd0);
    check({tag, ".foul"},      32'(bus.Foul),         32'd0);
    check({tag, ".buzz"},      32'(bus.Buzzer_Req),   32'd0);
    check({tag, ".time_over"}, 32'(bus.Time_Over),    32'd0);
    check({tag, ".timer"},     32'({bus.TimerH, bus.TimerL}), 32'(bcd(ANSWER_SEC)));
    check({tag, ".score"},     32'(bus.Score_Out),    32'd0);
  endtask

  // Full round: arm, player p wins, judge, release Start.
  task automatic play_round(input int p, input logic ok, input logic fail,
                            input logic [3:0] exp_score, input string tag);
    logic [3:0] key;
    key = 4'b0001 << p;
    drive(1'b1, 4'b0000, 1'b0, 1'b0); step();
    check({tag, ".armed"}, 32'(bus.State_Out), 32'd1);
    drive(1'b1, key, 1'b0, 1'b0); step();
    check({tag, ".win_id"}, 32'(bus.Winner_Id), 32'(p));
    drive(1'b1, 4'b0000, ok, fail); step();
    check({tag, ".done"}, 32'(bus.State_Out), 32'd4);
    check({tag, ".score"}, 32'(bus.Score_Out[p*SCORE_W +: SCORE_W]), 32'(exp_score));
    drive(1'b0, 4'b0000, 1'b0, 1'b0); step();
    check({tag, ".idle"}, 32'(bus.State_Out), 32'd0);
  endtask

  initial begin
    //                 start key     ok fail  st valid id led     foul   buzz score
    vecs.push_back(mk(1, 4'b0000, 0, 0, 3'd1, 0, 0, 4'b0000, 4'b0000, 0, 16'h0000));
    vecs.push_back(mk(1, 4'b0100, 0, 0, 3'd2, 1, 2, 4'b0100, 4'b0000, 1, 16'h0000));
    vecs.push_back(mk(1, 4'b0000, 0, 0, 3'd2, 1, 2, 4'b0100, 4'b0000, 0, 16'h0000));
    vecs.push_back(mk(1, 4'b1000, 0, 0, 3'd2, 1, 2, 4'b0100, 4'b0000, 0, 16'h0000));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 3'd4, 1, 2, 4'b0100, 4'b0000, 0, 16'h0000));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b0000, 0, 16'h0000));
    vecs.push_back(mk(1, 4'b0000, 0, 0, 3'd1, 0, 0, 4'b0000, 4'b0000, 0, 16'h0000));
    vecs.push_back(mk(1, 4'b0110, 0, 0, 3'd2, 1, 1, 4'b0010, 4'b0000, 1, 16'h0000));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b0000, 0, 16'h0000));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b0001, 0, 16'h0000));
    vecs.push_back(mk(1, 4'b0000, 0, 0, 3'd1, 0, 0, 4'b0000, 4'b0001, 0, 16'h0000));
    vecs.push_back(mk(1, 4'b0001, 0, 0, 3'd1, 0, 0, 4'b0000, 4'b0001, 0, 16'h0000));
    vecs.push_back(mk(1, 4'b0011, 0, 0, 3'd2, 1, 1, 4'b0010, 4'b0001, 1, 16'h0000));
    vecs.push_back(mk(1, 4'b0000, 1, 0, 3'd4, 1, 1, 4'b0010, 4'b0001, 0, 16'h0010));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b0000, 0, 16'h0010));
    vecs.push_back(mk(1, 4'b1111, 0, 0, 3'd1, 0, 0, 4'b0000, 4'b1111, 0, 16'h0010));
    vecs.push_back(mk(1, 4'b1111, 0, 0, 3'd1, 0, 0, 4'b0000, 4'b1111, 0, 16'h0010));
    vecs.push_back(mk(1, 4'b1111, 1, 0, 3'd1, 0, 0, 4'b0000, 4'b1111, 0, 16'h0010));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 3'd0, 0, 0, 4'b0000, 4'b0000, 0, 16'h0010));

    // Reset
    rst = 1'b1;
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    step(); step();
    rst = 1'b0;
    check_reset_values("reset");

    // Table-driven single-cycle vectors
    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].key, vecs[i].ok, vecs[i].fail);
      step();
      check($sformatf("v%0d.state", i), 32'(bus.State_Out),    32'(vecs[i].st));
      check($sformatf("v%0d.valid", i), 32'(bus.Winner_Valid), 32'(vecs[i].valid));
      check($sformatf("v%0d.id", i),    32'(bus.Winner_Id),    32'(vecs[i].id));
      check($sformatf("v%0d.led", i),   32'(bus.LED_Out),      32'(vecs[i].led));
      check($sformatf("v%0d.foul", i),  32'(bus.Foul),         32'(vecs[i].foul));
      check($sformatf("v%0d.buzz", i),  32'(bus.Buzzer_Req),   32'(vecs[i].buzz));
      check($sformatf("v%0d.score", i), 32'(bus.Score_Out),    32'(vecs[i].score));
      check($sformatf("v%0d.timer", i), 32'({bus.TimerH, bus.TimerL}), 32'(bcd(ANSWER_SEC)));
    end

    // Countdown to timeout: player 0 wins, nobody judges.
    drive(1'b1, 4'b0000, 1'b0, 1'b0); step();
    drive(1'b1, 4'b0001, 1'b0, 1'b0); step();
    check("cd.entry_timer", 32'({bus.TimerH, bus.TimerL}), 32'(bcd(30)));
    check("cd.entry_buzz",  32'(bus.Buzzer_Req), 32'd1);
    drive(1'b1, 4'b0000, 1'b0, 1'b0);
    for (int k = 1; k <= 120; k++) begin
      step();
      check($sformatf("cd.timer_k%0d", k), 32'({bus.TimerH, bus.TimerL}), 32'(bcd(30 - k / 4)));
      if (k < 120) begin
        check($sformatf("cd.state_k%0d", k), 32'(bus.State_Out), 32'd2);
        check($sformatf("cd.buzz_k%0d", k),  32'(bus.Buzzer_Req), 32'd0);
      end else begin
        check("cd.timeout_state", 32'(bus.State_Out),  32'd3);
        check("cd.time_over",     32'(bus.Time_Over),  32'd1);
        check("cd.timeout_buzz",  32'(bus.Buzzer_Req), 32'd1);
      end
    end
    drive(1'b1, 4'b1111, 1'b0, 1'b0); step();
    check("to.buzz_single", 32'(bus.Buzzer_Req), 32'd0);
    check("to.hold_state",  32'(bus.State_Out),  32'd3);
    check("to.hold_timer",  32'({bus.TimerH, bus.TimerL}), 32'h00);
    check("to.hold_led",    32'(bus.LED_Out),    32'b0001);
    drive(1'b1, 4'b0000, 1'b1, 1'b0); step();
    check("to.judge_ignored", 32'(bus.Score_Out), 32'h0010);
    check("to.time_over_hold", 32'(bus.Time_Over), 32'd1);
    drive(1'b0, 4'b0000, 1'b0, 1'b0); step();
    check("to.idle_state", 32'(bus.State_Out), 32'd0);
    check("to.idle_timer", 32'({bus.TimerH, bus.TimerL}), 32'(bcd(ANSWER_SEC)));
    check("to.idle_time_over", 32'(bus.Time_Over), 32'd0);

    // Score saturation for player 3; first round judges Ok and Fail together.
    for (int r = 0; r < 16; r++) begin
      play_round(3, 1'b1, (r == 0), 4'((r + 1 > 15) ? 15 : r + 1), $sformatf("sat%0d", r));
    end
    check("sat.score_word", 32'(bus.Score_Out), 32'hF010);

    // Judge pulse on the final tick: judge wins, no timeout beep.
    drive(1'b1, 4'b0000, 1'b0, 1'b0); step();
    drive(1'b1, 4'b1000, 1'b0, 1'b0); step();
    drive(1'b1, 4'b0000, 1'b0, 1'b0);
    for (int k = 1; k <= 119; k++) step();
    check("ft.timer_before", 32'({bus.TimerH, bus.TimerL}), 32'h01);
    drive(1'b1, 4'b0000, 1'b0, 1'b1); step();
    check("ft.state_done", 32'(bus.State_Out),  32'd4);
    check("ft.no_beep",    32'(bus.Buzzer_Req), 32'd0);
    check("ft.no_timeout", 32'(bus.Time_Over),  32'd0);
    drive(1'b1, 4'b0000, 1'b0, 1'b0); step();
    check("ft.no_beep_after", 32'(bus.Buzzer_Req), 32'd0);
    check("ft.score_kept",    32'(bus.Score_Out),  32'hF010);
    drive(1'b0, 4'b0000, 1'b0, 1'b0); step();

    // Reset mid-round with player 2 at score 5.
    for (int r = 0; r < 5; r++) begin
      play_round(2, 1'b1, 1'b0, 4'(r + 1), $sformatf("p2r%0d", r));
    end
    drive(1'b1, 4'b0000, 1'b0, 1'b0); step();
    drive(1'b1, 4'b0100, 1'b0, 1'b0); step();
    check("rr.in_answer", 32'(bus.State_Out), 32'd2);
    check("rr.scores",    32'(bus.Score_Out), 32'hF510);
    rst = 1'b1;
    drive(1'b1, 4'b1111, 1'b1, 1'b0); step();
    rst = 1'b0;
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    check_reset_values("rr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/responder_array.md
RESPONDER_ARRAY -- requirements
Module: responder_array

Interface
REQ-001 Parameter N_PLAYERS, default 4: number of contestants, range 2..16.
REQ-002 Parameter ANSWER_SEC, default 30: answer window in seconds, range 1..99.
REQ-003 Parameter TICK_CYC, default 50000000: CLK cycles per second tick, >= 2; benches override it with a small value.
REQ-004 Parameter SCORE_W, default 4: per-player score width.
REQ-005 Derived ID_W = max(1, clog2(N_PLAYERS)).
REQ-006 CLK  in  1  single clock; all logic on the rising edge.
REQ-007 Rst  in  1  synchronous, active-high reset.
REQ-008 Start  in  1  round enable level; already synchronous and debounced.
REQ-009 Key_In  in  N_PLAYERS  player buttons, 1 = pressed; already synchronous and debounced.
REQ-010 Judge_Ok  in  1  host marks the answer correct; one-cycle pulse.
REQ-011 Judge_Fail  in  1  host marks the answer wrong; one-cycle pulse.
REQ-012 Winner_Valid  out  1  a winner is latched.
REQ-013 Winner_Id  out  ID_W  index of the winning player.
REQ-014 LED_Out  out  N_PLAYERS  one-hot winner; zero when there is no winner.
REQ-015 Foul  out  N_PLAYERS  false-start flag per player.
REQ-016 TimerH, TimerL  out  4 each  BCD tens and units of the remaining answer time.
REQ-017 Time_Over  out  1  high while in TIMEOUT.
REQ-018 Buzzer_Req  out  1  one-cycle pulse requesting a beep.
REQ-019 Score_Out  out  N_PLAYERS*SCORE_W  player i occupies bits [i*SCORE_W +: SCORE_W].
REQ-020 State_Out  out  3  state encoding: IDLE=0, ARMED=1, ANSWER=2, TIMEOUT=3, DONE=4.

Function
REQ-021 FSM states are IDLE, ARMED, ANSWER, TIMEOUT and DONE; all outputs are registered.
REQ-022 IDLE with Start=1 goes to ARMED next cycle.
REQ-023 Start=0 in any non-IDLE state goes to IDLE next cycle.
REQ-024 Entering IDLE from another state clears Foul, Winner_Valid, LED_Out and Winner_Id.
REQ-025 IDLE: any Key_In[i]=1 sets Foul[i] next cycle; Foul[i] stays set until the next entry to IDLE or reset.
REQ-026 ARMED: eligible set is Key_In & ~Foul; if non-empty, the lowest eligible index wins.
REQ-027 A win in ARMED sets Winner_Valid, Winner_Id, LED_Out and pulses Buzzer_Req the next cycle (latency 1), and moves to ANSWER.
REQ-028 ARMED: presses by fouled players are ignored; if all players are fouled, the FSM stays in ARMED until Start=0.
REQ-029 Key_In outside IDLE and ARMED is ignored; the winner cannot change once latched.
REQ-030 On entry to ANSWER, TimerH:TimerL loads BCD ANSWER_SEC and the prescaler clears to 0.
REQ-031 The prescaler counts 0..TICK_CYC-1; the wrap produces a tick.
REQ-032 Each tick in ANSWER decrements the timer in BCD; when units=0, units become 9 and tens decrement.
REQ-033 A tick at 01 sets the timer to 00, moves to TIMEOUT and pulses Buzzer_Req, all in the same edge.
REQ-034 ANSWER with Judge_Ok: Score[Winner_Id] increments, saturating at 2^SCORE_W-1, and the FSM moves to DONE.
REQ-035 ANSWER with Judge_Fail: the FSM moves to DONE with no score change.
REQ-036 Judge_Ok and Judge_Fail together: Judge_Ok wins.
REQ-037 Judge pulse on the same cycle as the final tick: the judge wins, DONE is entered and there is no timeout beep.
REQ-038 Judge pulses outside ANSWER are ignored.
REQ-039 TIMEOUT and DONE hold the timer value and winner outputs until Start=0.
REQ-040 Outside ANSWER, TIMEOUT and DONE, the timer reads BCD ANSWER_SEC and the prescaler is held at 0.
REQ-041 Scores persist across rounds and clear only on Rst.

Reset
REQ-042 Rst=1 on a clock edge forces IDLE, takes priority over all inputs, and may occur mid-round.
REQ-043 Reset values: Foul=0, Winner_Valid=0, Winner_Id=0, LED_Out=0, Buzzer_Req=0, Time_Over=0, scores=0, prescaler=0, timer=BCD ANSWER_SEC, State_Out=0.

Verification (N_PLAYERS=4, ANSWER_SEC=30, TICK_CYC=4, SCORE_W=4)
REQ-044 Start=1, then Key_In=0100 -> next cycle LED_Out=0100, Winner_Id=2, one Buzzer_Req pulse, State_Out=2.
REQ-045 Key_In=0110 pressed in the same cycle while ARMED -> Winner_Id=1.
REQ-046 Key_In=0001 in IDLE, then Start=1, then Key_In=0011 -> Foul=0001, winner is player 1.
REQ-047 Win, then 120 cycles with no judge -> timer counts 30,29..01,00; at 00 Time_Over=1 with one Buzzer_Req pulse.
REQ-048 Sixteen winning rounds by player 3, each ended by Judge_Ok -> score 3 saturates at 15; Judge_Ok together with Judge_Fail counts as correct; a judge pulse on the final tick gives DONE with no beep.
REQ-049 Rst in ANSWER with score 2=5 -> next cycle every output equals the REQ-043 reset values.
